// File: rtl/thermostat_pkg.sv
`default_nettype none
// ============================================================================
// Module  : thermostat_pkg
// Purpose : Shared types and default constants for the thermostat sequencer.
//           Holds the sequencer state encoding and the default timing
//           parameters used by thermostat_sequencer and thermo_debounce.
// Revision: 1.0 - initial release
// ============================================================================
package thermostat_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_HEAT  = 2'd1,
    ST_COOL  = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  localparam int C_MIN_ON_CYC_DEF    = 8;
  localparam int C_MIN_OFF_CYC_DEF   = 16;
  localparam int C_FAN_TRAIL_CYC_DEF = 4;
  localparam int C_CNT_W_DEF         = 8;
  localparam int C_DEB_CYC_DEF       = 4;

endpackage : thermostat_pkg
`default_nettype wire

// File: rtl/thermo_debounce.sv
`default_nettype none
// ============================================================================
// Module  : thermo_debounce
// Purpose : 1-bit two-flop synchronizer followed by a stability filter. The
//           filtered output only takes a new value once the synchronized
//           input has differed from it for DEB_CYC consecutive cycles.
//           Total latency from input change to output is 2 + DEB_CYC cycles.
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset (output resets to 0)
//           i_d    - raw asynchronous input
//           o_q    - synchronized, filtered output
// Revision: 1.0 - initial release
// ============================================================================
module thermo_debounce
  import thermostat_pkg::*;
#(
  parameter int DEB_CYC = C_DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam int            C_CW   = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(DEB_CYC - 1);
  localparam logic [C_CW-1:0] C_ONE  = C_CW'(1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_q;
  logic [C_CW-1:0] r_cnt;

  // The counter tracks how long the synchronized input has disagreed with
  // the filtered value; any return to agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_q     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt >= C_LAST) begin
        r_q   <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  assign o_q = r_q;

endmodule : thermo_debounce
`default_nettype wire

// File: rtl/thermostat_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : thermostat_sequencer
// Purpose : Clocked heater / aircon / fan controller with short-cycle
//           protection (minimum on-time, minimum off-time lockout) and a fan
//           run-on period after every heat or cool cycle.
//           Optional macro THERMO_DEBOUNCE_EN: too_cold / too_hot pass
//           through thermo_debounce before the demand decode.
// Ports   : clk      - system clock, rising edge
//           rst_n    - asynchronous active-low reset
//           too_cold - room below setpoint
//           too_hot  - room above setpoint
//           mode     - 1 = heat mode, 0 = cool mode
//           fan_on   - manual fan request
//           heater   - heater enable (registered)
//           aircon   - aircon enable (registered)
//           fan      - fan enable (registered)
//           lockout  - off-time lockout active (registered)
// Revision: 1.0 - initial release
// ============================================================================
module thermostat_sequencer
  import thermostat_pkg::*;
#(
  parameter int MIN_ON_CYC    = C_MIN_ON_CYC_DEF,
  parameter int MIN_OFF_CYC   = C_MIN_OFF_CYC_DEF,
  parameter int FAN_TRAIL_CYC = C_FAN_TRAIL_CYC_DEF,
  parameter int CNT_W         = C_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic too_cold,
  input  logic too_hot,
  input  logic mode,
  input  logic fan_on,
  output logic heater,
  output logic aircon,
  output logic fan,
  output logic lockout
);

  localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ON_LAST    = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] C_TRAIL_LAST = CNT_W'(FAN_TRAIL_CYC - 1);
  localparam logic [CNT_W-1:0] C_OFF_LOAD   = CNT_W'(MIN_OFF_CYC);

  // --------------------------------------------------------------------------
  // Temperature input conditioning
  // --------------------------------------------------------------------------
  logic w_cold;
  logic w_hot;

`ifdef THERMO_DEBOUNCE_EN
  thermo_debounce #(
    .DEB_CYC (C_DEB_CYC_DEF)
  ) u_deb_cold (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (too_cold),
    .o_q   (w_cold)
  );

  thermo_debounce #(
    .DEB_CYC (C_DEB_CYC_DEF)
  ) u_deb_hot (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (too_hot),
    .o_q   (w_hot)
  );
`else
  assign w_cold = too_cold;
  assign w_hot  = too_hot;
`endif

  // A simultaneous cold/hot indication is a sensor conflict: no demand.
  logic w_heat_req;
  logic w_cool_req;

  assign w_heat_req =  mode & w_cold & ~w_hot;
  assign w_cool_req = ~mode & w_hot  & ~w_cold;

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_on_cnt;
  logic [CNT_W-1:0] r_off_cnt;
  logic [CNT_W-1:0] r_trail_cnt;
  logic             r_heater;
  logic             r_aircon;
  logic             r_fan;
  logic             r_lockout;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_on_cnt_nxt;
  logic [CNT_W-1:0] w_off_cnt_nxt;
  logic [CNT_W-1:0] w_trail_cnt_nxt;
  logic [CNT_W-1:0] w_on_cnt_inc;
  logic [CNT_W-1:0] w_trail_cnt_inc;
  logic             w_heater_nxt;
  logic             w_aircon_nxt;
  logic             w_fan_nxt;
  logic             w_lockout_nxt;
  logic             w_off_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_on_cnt    <= '0;
      r_off_cnt   <= '0;
      r_trail_cnt <= '0;
      r_heater    <= 1'b0;
      r_aircon    <= 1'b0;
      r_fan       <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_on_cnt    <= w_on_cnt_nxt;
      r_off_cnt   <= w_off_cnt_nxt;
      r_trail_cnt <= w_trail_cnt_nxt;
      r_heater    <= w_heater_nxt;
      r_aircon    <= w_aircon_nxt;
      r_fan       <= w_fan_nxt;
      r_lockout   <= w_lockout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_on_cnt_nxt    = r_on_cnt;
    w_trail_cnt_nxt = r_trail_cnt;
    w_off_clear     = (r_off_cnt == '0);
    w_on_cnt_inc    = (r_on_cnt    == C_CNT_MAX) ? r_on_cnt    : r_on_cnt    + C_CNT_ONE;
    w_trail_cnt_inc = (r_trail_cnt == C_CNT_MAX) ? r_trail_cnt : r_trail_cnt + C_CNT_ONE;
    // Off-time counts down whenever nonzero; it can only be nonzero in
    // TRAIL and IDLE because HEAT/COOL are entered with it at zero.
    w_off_cnt_nxt   = w_off_clear ? r_off_cnt : r_off_cnt - C_CNT_ONE;

    case (r_state)
      ST_IDLE: begin
        // Requests during lockout are not remembered; they must persist.
        if (w_heat_req && w_off_clear) begin
          w_state_nxt  = ST_HEAT;
          w_on_cnt_nxt = '0;
        end else if (w_cool_req && w_off_clear) begin
          w_state_nxt  = ST_COOL;
          w_on_cnt_nxt = '0;
        end
      end

      ST_HEAT: begin
        w_on_cnt_nxt = w_on_cnt_inc;
        if ((r_on_cnt >= C_ON_LAST) && !w_heat_req) begin
          w_state_nxt     = ST_TRAIL;
          w_off_cnt_nxt   = C_OFF_LOAD;
          w_trail_cnt_nxt = '0;
        end
      end

      ST_COOL: begin
        w_on_cnt_nxt = w_on_cnt_inc;
        if ((r_on_cnt >= C_ON_LAST) && !w_cool_req) begin
          w_state_nxt     = ST_TRAIL;
          w_off_cnt_nxt   = C_OFF_LOAD;
          w_trail_cnt_nxt = '0;
        end
      end

      ST_TRAIL: begin
        // Fixed-length run-on; demand is ignored until back in IDLE.
        w_trail_cnt_nxt = w_trail_cnt_inc;
        if (r_trail_cnt >= C_TRAIL_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are registered decodes of the next state, giving one cycle
    // of latency from input sample to actuator.
    w_heater_nxt  = (w_state_nxt == ST_HEAT);
    w_aircon_nxt  = (w_state_nxt == ST_COOL);
    w_fan_nxt     = (w_state_nxt == ST_IDLE) ? fan_on : 1'b1;
    w_lockout_nxt = (w_off_cnt_nxt != '0);
  end

  assign heater  = r_heater;
  assign aircon  = r_aircon;
  assign fan     = r_fan;
  assign lockout = r_lockout;

endmodule : thermostat_sequencer
`default_nettype wire

// File: tb/tb_thermostat_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_thermostat_sequencer
// Purpose : Directed self-checking bench for thermostat_sequencer with
//           MIN_ON_CYC=4, MIN_OFF_CYC=6, FAN_TRAIL_CYC=3, debounce disabled.
//           Expected {heater,aircon,fan,lockout} is queued as each step is
//           driven and compared after the following rising edge.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_thermostat_sequencer;

  logic clk;
  logic rst_n;
  logic too_cold;
  logic too_hot;
  logic mode;
  logic fan_on;
  logic heater;
  logic aircon;
  logic fan;
  logic lockout;

  thermostat_sequencer #(
    .MIN_ON_CYC    (4),
    .MIN_OFF_CYC   (6),
    .FAN_TRAIL_CYC (3),
    .CNT_W         (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .too_cold (too_cold),
    .too_hot  (too_hot),
    .mode     (mode),
    .fan_on   (fan_on),
    .heater   (heater),
    .aircon   (aircon),
    .fan      (fan),
    .lockout  (lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_cmp = 0;
  int       n_err = 0;

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check_pop();
    sb_item_t   it;
    logic [3:0] obs;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty obs=none exp=entry");
    end else begin
      it  = sb_q.pop_front();
      obs = {heater, aircon, fan, lockout};
      n_cmp++;
      assert (obs === it.exp) else begin
        n_err++;
        $error("FAIL %s obs(h,a,f,l)=%b exp=%b", it.tag, obs, it.exp);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs.
  task automatic step(input logic c, input logic h, input logic m,
                      input logic f, input logic [3:0] exp, input string tag);
    sb_item_t it;
    @(negedge clk);
    too_cold = c;
    too_hot  = h;
    mode     = m;
    fan_on   = f;
    it.exp   = exp;
    it.tag   = tag;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Remainder of TRAIL and lockout, starting with the edge after the one
  // that left HEAT/COOL; inputs idle.
  task automatic trail_tail(input string tag);
    step(0, 0, 0, 0, 4'b0011, tag);
    step(0, 0, 0, 0, 4'b0011, tag);
    step(0, 0, 0, 0, 4'b0001, tag);
    step(0, 0, 0, 0, 4'b0001, tag);
    step(0, 0, 0, 0, 4'b0001, tag);
    step(0, 0, 0, 0, 4'b0000, tag);
  endtask

  // Heater and aircon must never be on together.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      assert (!(heater && aircon)) else begin
        n_err++;
        $error("FAIL no_overlap obs=%b%b exp=not_both", heater, aircon);
      end
    end
  end

  initial begin
    sb_item_t it;
    rst_n    = 1'b0;
    too_cold = 1'b0;
    too_hot  = 1'b0;
    mode     = 1'b0;
    fan_on   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    it.exp = 4'b0000; it.tag = "reset_state";
    sb_q.push_back(it);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic heat cycle: one-cycle too_cold pulse.
    step(1, 0, 1, 0, 4'b1010, "heat_start");
    step(0, 0, 1, 0, 4'b1010, "heat_min_on");
    step(0, 0, 1, 0, 4'b1010, "heat_min_on");
    step(0, 0, 1, 0, 4'b1010, "heat_min_on");
    step(0, 0, 1, 0, 4'b0011, "heat_to_trail");
    trail_tail("heat_trail");

    // Long cool demand: too_hot held 10 cycles.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 4'b0110, "cool_long");
    step(0, 0, 0, 0, 4'b0011, "cool_fall");
    trail_tail("cool_trail");

    // Short-cycle protection: too_cold re-asserted as heater falls.
    step(1, 0, 1, 0, 4'b1010, "sc_start");
    step(0, 0, 1, 0, 4'b1010, "sc_on");
    step(0, 0, 1, 0, 4'b1010, "sc_on");
    step(0, 0, 1, 0, 4'b1010, "sc_on");
    step(0, 0, 1, 0, 4'b0011, "sc_fall");
    step(1, 0, 1, 0, 4'b0011, "sc_trail");
    step(1, 0, 1, 0, 4'b0011, "sc_trail");
    step(1, 0, 1, 0, 4'b0001, "sc_locked");
    step(1, 0, 1, 0, 4'b0001, "sc_locked");
    step(1, 0, 1, 0, 4'b0001, "sc_locked");
    step(1, 0, 1, 0, 4'b0000, "sc_lock_clear");
    step(1, 0, 1, 0, 4'b1010, "sc_restart");
    step(1, 0, 1, 0, 4'b1010, "sc_hold");
    step(1, 0, 1, 0, 4'b1010, "sc_hold");
    step(1, 0, 1, 0, 4'b1010, "sc_hold");
    step(0, 0, 1, 0, 4'b0011, "sc_fall2");
    trail_tail("sc_trail2");

    // Conflict plus manual fan.
    step(1, 1, 1, 1, 4'b0010, "conflict_heat_mode");
    step(1, 1, 0, 1, 4'b0010, "conflict_cool_mode");
    step(1, 1, 1, 0, 4'b0000, "fan_drop");

    // Mode flip during COOL.
    step(0, 1, 0, 0, 4'b0110, "flip_cool_start");
    step(1, 0, 1, 0, 4'b0110, "flip_cool_hold");
    step(1, 0, 1, 0, 4'b0110, "flip_cool_hold");
    step(1, 0, 1, 0, 4'b0110, "flip_cool_hold");
    step(1, 0, 1, 0, 4'b0011, "flip_trail");
    step(1, 0, 1, 0, 4'b0011, "flip_trail");
    step(1, 0, 1, 0, 4'b0011, "flip_trail");
    step(1, 0, 1, 0, 4'b0001, "flip_locked");
    step(1, 0, 1, 0, 4'b0001, "flip_locked");
    step(1, 0, 1, 0, 4'b0001, "flip_locked");
    step(1, 0, 1, 0, 4'b0000, "flip_lock_clear");
    step(1, 0, 1, 0, 4'b1010, "flip_heat_start");
    step(0, 0, 1, 0, 4'b1010, "flip_heat_on");
    step(0, 0, 1, 0, 4'b1010, "flip_heat_on");
    step(0, 0, 1, 0, 4'b1010, "flip_heat_on");
    step(0, 0, 1, 0, 4'b0011, "flip_heat_fall");
    trail_tail("flip_trail2");

    // Asynchronous reset in HEAT, then a clean restart.
    step(1, 0, 1, 0, 4'b1010, "ar_heat");
    step(0, 0, 1, 0, 4'b1010, "ar_heat");
    #2;
    rst_n = 1'b0;
    #1;
    it.exp = 4'b0000; it.tag = "async_reset_clear";
    sb_q.push_back(it);
    check_pop();
    rst_n = 1'b1;
    step(1, 0, 1, 0, 4'b1010, "ar_restart_no_lock");
    step(0, 0, 1, 0, 4'b1010, "ar_on");
    step(0, 0, 1, 0, 4'b1010, "ar_on");
    step(0, 0, 1, 0, 4'b1010, "ar_on");
    step(0, 0, 1, 0, 4'b0011, "ar_fall");
    trail_tail("ar_trail");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_thermostat_sequencer
`default_nettype wire
